// File: rtl/spike_step_scheduler.sv
// rtl/spike_step_scheduler.sv - step sequencer feeding one spike vector per step to a neuron core
// Loads a vector, holds it through setup, pulses start, counts output spikes until done, then gaps.
module spike_step_scheduler #(
  parameter int NUM_AXONS      = 4,
  parameter int STEP_CNT_WIDTH = 8,
  parameter int STOP_STEP      = 5,
  parameter int SETUP_CYCLES   = 2,
  parameter int GAP_CYCLES     = 100,
  parameter int TIMEOUT        = 1023,
  parameter int SPK_CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      in_valid,
  input  logic [NUM_AXONS-1:0]      in_spikes,
  output logic                      in_ready,
  output logic [NUM_AXONS-1:0]      nurn_spikes,
  output logic                      start,
  input  logic                      nurn_done,
  input  logic                      out_spike,
  output logic [STEP_CNT_WIDTH-1:0] step_count,
  output logic [SPK_CNT_WIDTH-1:0]  step_spikes,
  output logic                      busy,
  output logic                      finished,
  output logic                      timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_START, S_WAIT, S_GAP, S_DONE
  } state_t;

  localparam logic [15:0]               SETUP_LAST   = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0]               GAP_LAST     = 16'(GAP_CYCLES);
  localparam logic [9:0]                TIMEOUT_LAST = 10'(TIMEOUT - 1);
  localparam logic [STEP_CNT_WIDTH-1:0] STOP_VAL     = STEP_CNT_WIDTH'(STOP_STEP);

  state_t                     state;
  logic [15:0]                setup_cnt;
  logic [15:0]                gap_cnt;
  logic [9:0]                 wait_cnt;
  logic [SPK_CNT_WIDTH-1:0]   spike_cnt;
  logic [SPK_CNT_WIDTH-1:0]   spike_next;
  logic                       last_step;

  // Includes a spike arriving in the same cycle as completion; saturates at all-ones.
  assign spike_next = (out_spike && (spike_cnt != '1)) ? spike_cnt + 1'b1 : spike_cnt;
  assign last_step  = (STOP_STEP != 0) && (step_count == STOP_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      nurn_spikes <= '0;
      start       <= 1'b0;
      step_count  <= '0;
      step_spikes <= '0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      timeout_err <= 1'b0;
      setup_cnt   <= '0;
      gap_cnt     <= '0;
      wait_cnt    <= '0;
      spike_cnt   <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state       <= S_LOAD;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            finished    <= 1'b0;
            step_count  <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!run) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (in_valid && in_ready) begin
            nurn_spikes <= in_spikes;
            in_ready    <= 1'b0;
            setup_cnt   <= '0;
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          // start and step_count are raised on the same edge that enters START.
          if (setup_cnt == SETUP_LAST) begin
            state      <= S_START;
            start      <= 1'b1;
            step_count <= step_count + 1'b1;
            spike_cnt  <= '0;
            wait_cnt   <= '0;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (nurn_done) begin
            step_spikes <= spike_next;
            gap_cnt     <= '0;
            if (last_step) begin
              state    <= S_DONE;
              busy     <= 1'b0;
              finished <= 1'b1;
            end else begin
              state <= S_GAP;
            end
          end else if (wait_cnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_DONE;
            busy        <= 1'b0;
            finished    <= 1'b1;
          end else begin
            spike_cnt <= spike_next;
            wait_cnt  <= wait_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (run) begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (!run) begin
            state    <= S_IDLE;
            finished <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_step_scheduler.sv
// tb/tb_spike_step_scheduler.sv - directed self-checking bench for spike_step_scheduler
module tb_spike_step_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_spikes = 4'd0;
  logic       in_ready;
  logic [3:0] nurn_spikes;
  logic       start;
  logic       nurn_done = 1'b0;
  logic       out_spike = 1'b0;
  logic [7:0] step_count;
  logic [7:0] step_spikes;
  logic       busy;
  logic       finished;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int start_seen = 0;

  spike_step_scheduler #(
    .NUM_AXONS(4), .STEP_CNT_WIDTH(8), .STOP_STEP(5), .SETUP_CYCLES(2),
    .GAP_CYCLES(100), .TIMEOUT(1023), .SPK_CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .in_valid(in_valid), .in_spikes(in_spikes),
    .in_ready(in_ready), .nurn_spikes(nurn_spikes), .start(start), .nurn_done(nurn_done),
    .out_spike(out_spike), .step_count(step_count), .step_spikes(step_spikes),
    .busy(busy), .finished(finished), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start === 1'b1) start_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL wait_ready: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 8;
    if (in_ready !== 1'b0)    begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    if (nurn_spikes !== 4'd0) begin errors++; $display("FAIL reset_nurn_spikes: got %b want 0000", nurn_spikes); end
    if (start !== 1'b0)       begin errors++; $display("FAIL reset_start: got %b want 0", start); end
    if (step_count !== 8'd0)  begin errors++; $display("FAIL reset_step_count: got %0d want 0", step_count); end
    if (step_spikes !== 8'd0) begin errors++; $display("FAIL reset_step_spikes: got %0d want 0", step_spikes); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (finished !== 1'b0)    begin errors++; $display("FAIL reset_finished: got %b want 0", finished); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_five_steps();
    logic [3:0] vecs [5];
    int         ready_hi = 0;
    vecs = '{4'b1111, 4'b0010, 4'b1100, 4'b0100, 4'b0101};
    start_seen = 0;
    run = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_spikes = vecs[i];
      wait_ready();
      tick();
      checks += 2;
      if (nurn_spikes !== vecs[i]) begin errors++; $display("FAIL capture_%0d: got %b want %b", i, nurn_spikes, vecs[i]); end
      if (start !== 1'b0) begin errors++; $display("FAIL setup0_start_%0d: got %b want 0", i, start); end
      tick();
      checks++;
      if (start !== 1'b0) begin errors++; $display("FAIL setup1_start_%0d: got %b want 0", i, start); end
      tick();
      checks += 2;
      if (start !== 1'b1) begin errors++; $display("FAIL start_pulse_%0d: got %b want 1", i, start); end
      if (step_count !== 8'(i + 1)) begin errors++; $display("FAIL step_count_%0d: got %0d want %0d", i, step_count, i + 1); end
      repeat (19) tick();
      checks += 2;
      if (start !== 1'b0) begin errors++; $display("FAIL start_width_%0d: got %b want 0", i, start); end
      if (nurn_spikes !== vecs[i]) begin errors++; $display("FAIL hold_%0d: got %b want %b", i, nurn_spikes, vecs[i]); end
      nurn_done = 1'b1;
      tick();
      nurn_done = 1'b0;
    end
    checks += 4;
    if (finished !== 1'b1)    begin errors++; $display("FAIL five_finished: got %b want 1", finished); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL five_busy: got %b want 0", busy); end
    if (step_spikes !== 8'd0) begin errors++; $display("FAIL five_step_spikes: got %0d want 0", step_spikes); end
    if (start_seen != 5)      begin errors++; $display("FAIL five_start_count: got %0d want 5", start_seen); end
    repeat (150) begin
      tick();
      if (in_ready === 1'b1) ready_hi++;
    end
    checks++;
    if (ready_hi != 0) begin errors++; $display("FAIL done_no_ready: in_ready high %0d cycles, want 0", ready_hi); end
    run = 1'b0;
    tick();
    checks++;
    if (finished !== 1'b0) begin errors++; $display("FAIL done_exit_finished: got %b want 0", finished); end
  endtask

  task automatic test_spike_count();
    run = 1'b1;
    in_valid = 1'b1;
    in_spikes = 4'b1010;
    wait_ready();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    out_spike = 1'b1; tick();
    out_spike = 1'b0; tick();
    out_spike = 1'b1; tick();
    out_spike = 1'b0; tick();
    out_spike = 1'b1; nurn_done = 1'b1; tick();
    out_spike = 1'b0; nurn_done = 1'b0;
    checks++;
    if (step_spikes !== 8'd3) begin errors++; $display("FAIL spike_count: got %0d want 3", step_spikes); end
    out_spike = 1'b1;
    repeat (3) tick();
    out_spike = 1'b0;
    repeat (97) tick();
    checks += 2;
    if (step_spikes !== 8'd3) begin errors++; $display("FAIL gap_spikes_ignored: got %0d want 3", step_spikes); end
    if (in_ready !== 1'b0)    begin errors++; $display("FAIL gap_early_ready: got %b want 0", in_ready); end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL gap_ready_edge: got %b want 1", in_ready); end
  endtask

  task automatic test_run_drop();
    int starts_before;
    in_spikes = 4'b0011;
    in_valid = 1'b1;
    wait_ready();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    run = 1'b0;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL run_drop_wait_busy: got %b want 1", busy); end
    nurn_done = 1'b1;
    tick();
    nurn_done = 1'b0;
    checks++;
    if (step_count !== 8'd2) begin errors++; $display("FAIL run_drop_step_count: got %0d want 2", step_count); end
    repeat (100) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL run_drop_gap_busy: got %b want 1", busy); end
    tick();
    checks += 2;
    if (busy !== 1'b0)     begin errors++; $display("FAIL run_drop_idle_busy: got %b want 0", busy); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL run_drop_idle_ready: got %b want 0", in_ready); end
    run = 1'b1;
    tick();
    starts_before = start_seen;
    repeat (50) tick();
    checks += 3;
    if (in_ready !== 1'b1)          begin errors++; $display("FAIL stall_ready: got %b want 1", in_ready); end
    if (start_seen != starts_before) begin errors++; $display("FAIL stall_no_start: got %0d starts want 0", start_seen - starts_before); end
    if (step_count !== 8'd0)        begin errors++; $display("FAIL stall_step_count: got %0d want 0", step_count); end
    run = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_exit_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_timeout();
    run = 1'b1;
    in_valid = 1'b1;
    in_spikes = 4'b1001;
    wait_ready();
    tick();
    tick();
    tick();
    repeat (1023) tick();
    checks += 2;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", timeout_err); end
    if (finished !== 1'b0)    begin errors++; $display("FAIL timeout_early_done: got %b want 0", finished); end
    tick();
    checks += 3;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", timeout_err); end
    if (finished !== 1'b1)    begin errors++; $display("FAIL timeout_finished: got %b want 1", finished); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL timeout_busy: got %b want 0", busy); end
    run = 1'b0;
    tick();
    checks += 2;
    if (finished !== 1'b0)    begin errors++; $display("FAIL timeout_idle_finished: got %b want 0", finished); end
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
    run = 1'b1;
    tick();
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_timeout_race();
    wait_ready();
    tick();
    tick();
    tick();
    repeat (1023) tick();
    nurn_done = 1'b1;
    tick();
    nurn_done = 1'b0;
    checks += 4;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL race_timeout_err: got %b want 0", timeout_err); end
    if (finished !== 1'b0)    begin errors++; $display("FAIL race_finished: got %b want 0", finished); end
    if (busy !== 1'b1)        begin errors++; $display("FAIL race_busy: got %b want 1", busy); end
    if (step_count !== 8'd1)  begin errors++; $display("FAIL race_step_count: got %0d want 1", step_count); end
  endtask

  task automatic test_reset_midwait();
    in_spikes = 4'b0110;
    wait_ready();
    tick();
    tick();
    tick();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checks += 8;
    if (in_ready !== 1'b0)    begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (nurn_spikes !== 4'd0) begin errors++; $display("FAIL rst_nurn_spikes: got %b want 0000", nurn_spikes); end
    if (start !== 1'b0)       begin errors++; $display("FAIL rst_start: got %b want 0", start); end
    if (step_count !== 8'd0)  begin errors++; $display("FAIL rst_step_count: got %0d want 0", step_count); end
    if (step_spikes !== 8'd0) begin errors++; $display("FAIL rst_step_spikes: got %0d want 0", step_spikes); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (finished !== 1'b0)    begin errors++; $display("FAIL rst_finished: got %b want 0", finished); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    rst = 1'b0;
    wait_ready();
    tick();
    tick();
    tick();
    checks += 2;
    if (start !== 1'b1)      begin errors++; $display("FAIL restart_start: got %b want 1", start); end
    if (step_count !== 8'd1) begin errors++; $display("FAIL restart_step_count: got %0d want 1", step_count); end
  endtask

  initial begin
    test_reset();
    test_five_steps();
    test_spike_count();
    test_run_drop();
    test_timeout();
    test_timeout_race();
    test_reset_midwait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
